// File: rtl/jtframe_mist_ctrl_pkg.sv
// Shared bit positions and constants for the MiST board-control glue.
// Joystick indices follow the raw MiST word; status indices follow the OSD word.
package jtframe_mist_pkg;

   localparam int JOY_R     = 0;
   localparam int JOY_L     = 1;
   localparam int JOY_D     = 2;
   localparam int JOY_U     = 3;
   localparam int JOY_B1    = 4;
   localparam int JOY_START = 10;
   localparam int JOY_COIN  = 11;
   localparam int JOY_PAUSE = 12;

   localparam int ST_RST  = 0;
   localparam int ST_FLIP = 1;
   localparam int ST_ROT  = 2;
   localparam int ST_SCAN = 3;   // two bits wide
   localparam int ST_FX   = 6;   // two bits wide
   localparam int ST_PSG  = 8;
   localparam int ST_FM   = 9;
   localparam int ST_TEST = 10;
   localparam int ST_CRED = 12;

   localparam logic [1:0] FX_XOR = 2'b10;

   // The OSD menu lists fx levels in an order offset from the game's encoding.
   function automatic logic [1:0] fx_decode(input logic [1:0] raw);
      return raw ^ FX_XOR;
   endfunction

endpackage

// File: rtl/jtframe_mist_ctrl_joymap.sv
// Per-player joystick packing: optional clockwise rotation of the directions
// for vertical games, masking of unused fire buttons, and active-low output.
module jtframe_joymap
   import jtframe_mist_pkg::*;
#(
   parameter int BUTTONS  = 2,
   parameter int VERTICAL = 0
)(
   input  logic [9:0] joy_bits,
   input  logic       rot,
   output logic [9:0] game_joy
);

   logic [5:0] btn_act;
   logic       up, down, left, right;
   logic       rot_en;

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_btn
         if (gi < BUTTONS) begin : g_used
            assign btn_act[gi] = joy_bits[JOY_B1 + gi];
         end else begin : g_unused
            assign btn_act[gi] = 1'b0;
         end
      end
   endgenerate

   assign rot_en = (VERTICAL != 0) && rot;

   always_comb begin
      up    = joy_bits[JOY_U];
      down  = joy_bits[JOY_D];
      left  = joy_bits[JOY_L];
      right = joy_bits[JOY_R];
      if (rot_en) begin
         up    = joy_bits[JOY_L];
         right = joy_bits[JOY_U];
         down  = joy_bits[JOY_R];
         left  = joy_bits[JOY_D];
      end
      game_joy = ~{btn_act, up, down, left, right};
   end

endmodule

// File: rtl/jtframe_mist_ctrl.sv
// MiST board-control glue: game reset sequencing, OSD status decode,
// joystick/coin/start mapping, pause toggle and user LED. All outputs registered.
module jtframe_mist_ctrl
   import jtframe_mist_pkg::*;
#(
   parameter int BUTTONS  = 2,
   parameter int VERTICAL = 0,
   parameter int RSTCNT   = 16
)(
   input  logic        clk_sys,
   input  logic        rst,
   input  logic [31:0] status,
   input  logic        downloading,
   input  logic [31:0] joystick1,
   input  logic [31:0] joystick2,
   output logic        game_rst,
   output logic [9:0]  game_joystick1,
   output logic [9:0]  game_joystick2,
   output logic [3:0]  game_coin,
   output logic [3:0]  game_start,
   output logic        dip_flip,
   output logic        dip_test,
   output logic [1:0]  dip_fxlevel,
   output logic        enable_psg,
   output logic        enable_fm,
   output logic [1:0]  scanlines,
   output logic        osd_credits,
   output logic        dip_pause,
   output logic        LED
);

   localparam int CW = (RSTCNT > 1) ? $clog2(RSTCNT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(RSTCNT - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          zero_q, zero_d;
   logic          game_rst_q, game_rst_d;
   logic [9:0]    joy1_q, joy1_d, joy2_q, joy2_d;
   logic [3:0]    coin_q, coin_d, start_q, start_d;
   logic          flip_q, flip_d, test_q, test_d;
   logic [1:0]    fx_q, fx_d, scan_q, scan_d;
   logic          psg_q, psg_d, fm_q, fm_d, cred_q, cred_d;
   logic          pause_q, pause_d, pause_or_q, pause_or_d;
   logic          led_q, led_d;
   logic          rst_src;
   logic          unused_bits;

   assign unused_bits = &{1'b0, status[31:13], status[11], status[5],
                          joystick1[31:13], joystick2[31:13]};

   jtframe_joymap #(.BUTTONS(BUTTONS), .VERTICAL(VERTICAL)) u_joy1 (
      .joy_bits (joystick1[9:0]),
      .rot      (status[ST_ROT]),
      .game_joy (joy1_d)
   );

   jtframe_joymap #(.BUTTONS(BUTTONS), .VERTICAL(VERTICAL)) u_joy2 (
      .joy_bits (joystick2[9:0]),
      .rot      (status[ST_ROT]),
      .game_joy (joy2_d)
   );

   assign rst_src = rst | status[ST_RST] | downloading;

   always_comb begin
      // zero_q delays the release one cycle past the counter reaching 0,
      // giving RSTCNT+1 cycles from the last source falling.
      cnt_d      = cnt_q;
      zero_d     = 1'b0;
      game_rst_d = 1'b1;
      if (rst_src) begin
         cnt_d = CNT_LOAD;
      end else begin
         if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
         zero_d     = (cnt_q == '0);
         game_rst_d = ~zero_q;
      end

      coin_d  = {2'b11, ~joystick2[JOY_COIN],  ~joystick1[JOY_COIN]};
      start_d = {2'b11, ~joystick2[JOY_START], ~joystick1[JOY_START]};

      flip_d = status[ST_FLIP];
      test_d = status[ST_TEST];
      fx_d   = fx_decode(status[ST_FX +: 2]);
      psg_d  = ~status[ST_PSG];
      fm_d   = ~status[ST_FM];
      scan_d = status[ST_SCAN +: 2];
      cred_d = status[ST_CRED];

      pause_or_d = joystick1[JOY_PAUSE] | joystick2[JOY_PAUSE];
      pause_d    = pause_q;
      if (game_rst_q)
         pause_d = 1'b1;
      else if (pause_or_d && !pause_or_q)
         pause_d = ~pause_q;

      led_d = downloading | ~pause_d;
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         cnt_q      <= CNT_LOAD;
         zero_q     <= 1'b0;
         game_rst_q <= 1'b1;
         joy1_q     <= '1;
         joy2_q     <= '1;
         coin_q     <= '1;
         start_q    <= '1;
         flip_q     <= 1'b0;
         test_q     <= 1'b0;
         fx_q       <= FX_XOR;
         psg_q      <= 1'b1;
         fm_q       <= 1'b1;
         scan_q     <= 2'b00;
         cred_q     <= 1'b0;
         pause_q    <= 1'b1;
         pause_or_q <= 1'b0;
         led_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         zero_q     <= zero_d;
         game_rst_q <= game_rst_d;
         joy1_q     <= joy1_d;
         joy2_q     <= joy2_d;
         coin_q     <= coin_d;
         start_q    <= start_d;
         flip_q     <= flip_d;
         test_q     <= test_d;
         fx_q       <= fx_d;
         psg_q      <= psg_d;
         fm_q       <= fm_d;
         scan_q     <= scan_d;
         cred_q     <= cred_d;
         pause_q    <= pause_d;
         pause_or_q <= pause_or_d;
         led_q      <= led_d;
      end
   end

   assign game_rst       = game_rst_q;
   assign game_joystick1 = joy1_q;
   assign game_joystick2 = joy2_q;
   assign game_coin      = coin_q;
   assign game_start     = start_q;
   assign dip_flip       = flip_q;
   assign dip_test       = test_q;
   assign dip_fxlevel    = fx_q;
   assign enable_psg     = psg_q;
   assign enable_fm      = fm_q;
   assign scanlines      = scan_q;
   assign osd_credits    = cred_q;
   assign dip_pause      = pause_q;
   assign LED            = led_q;

endmodule

// File: tb/tb_jtframe_mist_ctrl.sv
// Directed bench for jtframe_mist_ctrl (BUTTONS=2, VERTICAL=1, RSTCNT=16)
// with hand-computed expectations; one line per checked transaction.
module tb_jtframe_mist_ctrl;

   logic        clk_sys = 1'b0;
   logic        rst;
   logic [31:0] status;
   logic        downloading;
   logic [31:0] joystick1, joystick2;
   logic        game_rst;
   logic [9:0]  game_joystick1, game_joystick2;
   logic [3:0]  game_coin, game_start;
   logic        dip_flip, dip_test, enable_psg, enable_fm, osd_credits, dip_pause, LED;
   logic [1:0]  dip_fxlevel, scanlines;

   int checks   = 0;
   int failures = 0;

   jtframe_mist_ctrl #(.BUTTONS(2), .VERTICAL(1), .RSTCNT(16)) dut (
      .clk_sys        (clk_sys),
      .rst            (rst),
      .status         (status),
      .downloading    (downloading),
      .joystick1      (joystick1),
      .joystick2      (joystick2),
      .game_rst       (game_rst),
      .game_joystick1 (game_joystick1),
      .game_joystick2 (game_joystick2),
      .game_coin      (game_coin),
      .game_start     (game_start),
      .dip_flip       (dip_flip),
      .dip_test       (dip_test),
      .dip_fxlevel    (dip_fxlevel),
      .enable_psg     (enable_psg),
      .enable_fm      (enable_fm),
      .scanlines      (scanlines),
      .osd_credits    (osd_credits),
      .dip_pause      (dip_pause),
      .LED            (LED)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   // Cycles from the source dropping until game_rst reads 0, bounded.
   task automatic rst_release(input string tag);
      int n;
      n = 0;
      do begin
         step(1);
         n++;
      end while (game_rst && n < 100);
      check(tag, n, 17);
   endtask

   initial begin
      rst = 1'b1; status = '0; downloading = 1'b0;
      joystick1 = '0; joystick2 = '0;
      step(5);
      check("rst_game_rst", game_rst, 1);
      check("rst_joy1", game_joystick1, 10'h3FF);
      check("rst_joy2", game_joystick2, 10'h3FF);
      check("rst_coin", game_coin, 4'hF);
      check("rst_start", game_start, 4'hF);
      check("rst_pause", dip_pause, 1);
      check("rst_led", LED, 0);
      check("rst_dips", {dip_flip, dip_test, dip_fxlevel, enable_psg, enable_fm, scanlines, osd_credits},
            {1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0});

      rst = 1'b0;
      rst_release("rst_release_len");
      check("post_rst_pause", dip_pause, 1);
      check("post_rst_led", LED, 0);

      // Joystick mapping
      joystick1 = 32'h0000_0C19; step(1);
      check("joy1_c19", game_joystick1, 10'h3E6);
      check("start_c19", game_start, 4'hE);
      check("coin_c19", game_coin, 4'hE);
      check("joy2_idle", game_joystick2, 10'h3FF);
      joystick1 = 32'h0000_0049; joystick2 = 32'h0000_0C22; step(1);
      check("joy1_btn3_masked", game_joystick1, 10'h3F6);
      check("joy2_c22", game_joystick2, 10'h3DD);
      check("start_p2", game_start, 4'hD);
      check("coin_p2", game_coin, 4'hD);
      joystick2 = '0;

      // Rotation
      joystick1 = 32'h8; status = 32'h4; step(1);
      check("rot_up_to_right", game_joystick1, 10'h3FE);
      status = 32'h0; step(1);
      check("norot_up", game_joystick1, 10'h3F7);
      joystick1 = 32'h2; status = 32'h4; step(1);
      check("rot_left_to_up", game_joystick1, 10'h3F7);
      joystick1 = '0;

      // Status decode
      status = 32'h0000_1346; step(1);
      check("st1346_dips", {dip_flip, dip_test, dip_fxlevel, enable_psg, enable_fm, scanlines, osd_credits},
            {1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b1});
      status = 32'h0000_0498; step(1);
      check("st0498_dips", {dip_flip, dip_test, dip_fxlevel, enable_psg, enable_fm, scanlines, osd_credits},
            {1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 2'b11, 1'b0});
      check("st_no_rst", game_rst, 0);
      status = 32'h1; step(1);
      check("st_rst_bit", game_rst, 1);
      status = 32'h0;
      rst_release("st_rst_release_len");

      // Pause toggling
      joystick2 = 32'h1000; step(1);
      check("pause_pulse1", dip_pause, 0);
      check("pause_led", LED, 1);
      joystick2 = '0; step(2);
      joystick2 = 32'h1000; step(1);
      check("pause_pulse2", dip_pause, 1);
      step(4);
      check("pause_held", dip_pause, 1);
      joystick2 = '0; step(1);
      joystick1 = 32'h1000; step(1);
      check("pause_p1", dip_pause, 0);
      joystick1 = '0;
      status = 32'h1; step(2);
      check("pause_cleared_by_rst", dip_pause, 1);
      status = 32'h0;
      rst_release("pause_rst_release_len");

      // Download
      downloading = 1'b1; step(1);
      check("dl_game_rst", game_rst, 1);
      check("dl_led", LED, 1);
      step(98);
      check("dl_led_mid", LED, 1);
      check("dl_game_rst_mid", game_rst, 1);
      step(1);
      downloading = 1'b0;
      rst_release("dl_release_len");
      check("dl_led_after", LED, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
